// File: rtl/approx_adder_error_checker.sv
// Exhaustive sweep checker for a combinational approximate adder.
// Optional FIRST_FAIL_CAPTURE_EN adds first-violation capture ports.
module approx_adder_error_checker #(
  parameter int OPERAND_W = 2,
  parameter int ET        = 5
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  output logic [2*OPERAND_W-1:0]              dut_in,
  input  logic [OPERAND_W:0]                  dut_sum,
  output logic                                busy,
  output logic                                done,
  output logic [OPERAND_W:0]                  max_err,
  output logic [3*OPERAND_W:0]                err_sum,
  output logic [2*OPERAND_W:0]                fail_cnt,
  output logic                                pass
`ifdef FIRST_FAIL_CAPTURE_EN
  ,
  output logic [2*OPERAND_W-1:0]              first_fail_vec,
  output logic [OPERAND_W:0]                  first_fail_sum
`endif
);

  localparam int VEC_W = 2 * OPERAND_W;
  localparam int SUM_W = OPERAND_W + 1;
  localparam int CNT_W = VEC_W + 1;
  localparam int ACC_W = SUM_W + VEC_W;
  localparam logic [31:0] ET_U = 32'(ET);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE,
    DONE
  } state_t;

  state_t state;

  logic [OPERAND_W-1:0] a;
  logic [OPERAND_W-1:0] b;
  logic [SUM_W-1:0]     exact;
  logic [SUM_W:0]       diff;
  logic [SUM_W:0]       mag;
  logic [SUM_W-1:0]     err;
  logic                 viol;
  logic                 last;

  assign a     = dut_in[OPERAND_W-1:0];
  assign b     = dut_in[VEC_W-1:OPERAND_W];
  assign exact = SUM_W'(a) + SUM_W'(b);
  // two's-complement difference; the top bit is the sign
  assign diff  = {1'b0, dut_sum} - {1'b0, exact};
  assign mag   = diff[SUM_W] ? (~diff + (SUM_W+1)'(1)) : diff;
  assign err   = mag[SUM_W-1:0];
  assign viol  = 32'(err) > ET_U;
  assign last  = &dut_in;

  assign pass  = done && (32'(max_err) <= ET_U);

`ifdef FIRST_FAIL_CAPTURE_EN
  logic hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      dut_in   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      max_err  <= '0;
      err_sum  <= '0;
      fail_cnt <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
      hit            <= 1'b0;
      first_fail_vec <= '0;
      first_fail_sum <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= DRIVE;
            dut_in   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            max_err  <= '0;
            err_sum  <= '0;
            fail_cnt <= '0;
`ifdef FIRST_FAIL_CAPTURE_EN
            hit            <= 1'b0;
            first_fail_vec <= '0;
            first_fail_sum <= '0;
`endif
          end
        end
        DRIVE: begin
          state <= SAMPLE;
        end
        SAMPLE: begin
          if (err > max_err) max_err <= err;
          err_sum  <= err_sum + ACC_W'(err);
          fail_cnt <= fail_cnt + CNT_W'(viol);
`ifdef FIRST_FAIL_CAPTURE_EN
          if (viol && !hit) begin
            hit            <= 1'b1;
            first_fail_vec <= dut_in;
            first_fail_sum <= dut_sum;
          end
`endif
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            state  <= DRIVE;
            dut_in <= dut_in + VEC_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_approx_adder_error_checker.sv
// Directed bench: exact / stuck-0 / stuck-7 adder models plus protocol cases.
module tb_approx_adder_error_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] dut_in;
  logic [2:0] dut_sum;
  logic       busy;
  logic       done;
  logic [2:0] max_err;
  logic [6:0] err_sum;
  logic [4:0] fail_cnt;
  logic       pass;
`ifdef FIRST_FAIL_CAPTURE_EN
  logic [3:0] first_fail_vec;
  logic [2:0] first_fail_sum;
`endif

  int mode;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  approx_adder_error_checker #(.OPERAND_W(2), .ET(5)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dut_in(dut_in),
    .dut_sum(dut_sum),
    .busy(busy),
    .done(done),
    .max_err(max_err),
    .err_sum(err_sum),
    .fail_cnt(fail_cnt),
    .pass(pass)
`ifdef FIRST_FAIL_CAPTURE_EN
    ,
    .first_fail_vec(first_fail_vec),
    .first_fail_sum(first_fail_sum)
`endif
  );

  // adder models: 0 exact, 1 stuck at 0, 2 stuck at 7
  always_comb begin
    dut_sum = 3'd0;
    case (mode)
      0: dut_sum = {1'b0, dut_in[1:0]} + {1'b0, dut_in[3:2]};
      1: dut_sum = 3'd0;
      default: dut_sum = 3'd7;
    endcase
  end

  typedef struct {
    int mode;
    int mx;
    int es;
    int fc;
    int ps;
    int fv;
    int fs;
  } vec_t;

  vec_t tab[3];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " dut_in"}, int'(dut_in), 0);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " done"}, int'(done), 0);
    chk({tag, " max_err"}, int'(max_err), 0);
    chk({tag, " err_sum"}, int'(err_sum), 0);
    chk({tag, " fail_cnt"}, int'(fail_cnt), 0);
    chk({tag, " pass"}, int'(pass), 0);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk({tag, " ff_vec"}, int'(first_fail_vec), 0);
    chk({tag, " ff_sum"}, int'(first_fail_sum), 0);
`endif
  endtask

  // edges counted from the edge that samples start (that edge = 1)
  task automatic run_sweep(input bit pulse, input bit chk_clr,
                           output int n);
    @(negedge clk);
    start = 1'b1;
    n = 0;
    @(posedge clk);
    n = 1;
    @(negedge clk);
    start = 1'b0;
    if (chk_clr) begin
      chk("restart busy", int'(busy), 1);
      chk("restart done", int'(done), 0);
      chk("restart dut_in", int'(dut_in), 0);
      chk("restart err_sum", int'(err_sum), 0);
      chk("restart max_err", int'(max_err), 0);
      chk("restart fail_cnt", int'(fail_cnt), 0);
    end
    while (!done && n < 200) begin
      start = pulse && (n == 5 || n == 12 || n == 20);
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic chk_results(input string tag, input vec_t v);
    chk({tag, " done"}, int'(done), 1);
    chk({tag, " busy"}, int'(busy), 0);
    chk({tag, " dut_in"}, int'(dut_in), 15);
    chk({tag, " max_err"}, int'(max_err), v.mx);
    chk({tag, " err_sum"}, int'(err_sum), v.es);
    chk({tag, " fail_cnt"}, int'(fail_cnt), v.fc);
    chk({tag, " pass"}, int'(pass), v.ps);
`ifdef FIRST_FAIL_CAPTURE_EN
    chk({tag, " ff_vec"}, int'(first_fail_vec), v.fv);
    chk({tag, " ff_sum"}, int'(first_fail_sum), v.fs);
`endif
  endtask

  initial begin
    int n;
    tab[0] = '{mode: 0, mx: 0, es: 0,  fc: 0, ps: 1, fv: 0,  fs: 0};
    tab[1] = '{mode: 1, mx: 6, es: 48, fc: 1, ps: 0, fv: 15, fs: 0};
    tab[2] = '{mode: 2, mx: 7, es: 64, fc: 3, ps: 0, fv: 0,  fs: 7};

    mode  = 0;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");

    for (int i = 0; i < 3; i++) begin
      mode = tab[i].mode;
      run_sweep(1'b0, 1'b0, n);
      chk($sformatf("vec%0d done_cycle", i), n, 33);
      chk_results($sformatf("vec%0d", i), tab[i]);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d hold err_sum", i), int'(err_sum), tab[i].es);
    end

    // reset in the middle of a stuck-0 sweep
    mode = 1;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("mid busy", int'(busy), 1);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    chk_reset_vals("midrst");
    repeat (2) @(negedge clk);
    chk("idle stays", int'(busy), 0);
    run_sweep(1'b0, 1'b0, n);
    chk("after rst done_cycle", n, 33);
    chk_results("after rst", tab[1]);

    // start pulses while busy
    mode = 0;
    run_sweep(1'b1, 1'b0, n);
    chk("busy start done_cycle", n, 33);
    chk_results("busy start", tab[0]);

    // restart from DONE clears accumulators, repeats results
    mode = 2;
    run_sweep(1'b0, 1'b0, n);
    chk_results("first of two", tab[2]);
    run_sweep(1'b0, 1'b1, n);
    chk("second done_cycle", n, 33);
    chk_results("second of two", tab[2]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
